reg_overlay_scan: RTL and testbench

Scan-side front end for the on-screen register dump. From the VGA timing generator's pixel coordinates it decides whether the current pixel falls inside the register window. For pixels inside, it presents a frame-stable 16-bit register value plus glyph `line` and `column` to the hex glyph renderer, which maps them to a pixel bit. It also delays the sync/active strobes so they stay aligned, and generates a blinking highlight for one selected register.

---
 rtl/overlay_pkg.sv | 15 +
 rtl/reg_overlay_hit.sv | 63 ++++++
 rtl/reg_overlay_scan.sv | 123 ++++++++++++
 tb/tb_reg_overlay_scan.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/overlay_pkg.sv
// Shared constants for the on-screen overlay layers (glyph geometry, pipeline depth).
package overlay_pkg;

  localparam int GLYPH_W    = 32;
  localparam int GLYPH_H    = 8;
  localparam int DIGITS     = 4;
  localparam int REG_W      = 16;
  localparam int PIPE_DEPTH = 2;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_overlay_hit.sv
// Stage 1 of the overlay scan: screen-to-glyph coordinate transform and window test.
module reg_overlay_hit
  import overlay_pkg::*;
#(
  parameter int X0          = 64,
  parameter int Y0          = 32,
  parameter int SCALE_SHIFT = 1,
  parameter int ROWS        = 8,
  parameter int GY_W        = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [9:0]      px_x,
  input  logic [9:0]      px_y,
  input  logic            px_active,
  input  logic            hsync_in,
  input  logic            vsync_in,
  output logic            hit,
  output logic [4:0]      gx,
  output logic [GY_W-1:0] gy,
  output logic            hsync,
  output logic            vsync,
  output logic            active
);

  localparam logic [10:0] X0_W     = 11'(X0);
  localparam logic [10:0] Y0_W     = 11'(Y0);
  localparam logic [9:0]  GX_LIMIT = 10'(GLYPH_W);
  localparam logic [9:0]  GY_LIMIT = 10'(ROWS * GLYPH_H);

  logic [10:0] dx;
  logic [10:0] dy;
  logic [9:0]  gx_full;
  logic [9:0]  gy_full;
  logic        in_window;

  // Bit 10 is the borrow: pixels left of or above the window come out negative.
  assign dx        = {1'b0, px_x} - X0_W;
  assign dy        = {1'b0, px_y} - Y0_W;
  assign gx_full   = dx[9:0] >> SCALE_SHIFT;
  assign gy_full   = dy[9:0] >> SCALE_SHIFT;
  assign in_window = px_active & ~dx[10] & ~dy[10] &
                     (gx_full < GX_LIMIT) & (gy_full < GY_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      hit    <= 1'b0;
      gx     <= '0;
      gy     <= '0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      active <= 1'b0;
    end else begin
      hit    <= in_window;
      gx     <= gx_full[4:0];
      gy     <= gy_full[GY_W-1:0];
      hsync  <= hsync_in;
      vsync  <= vsync_in;
      active <= px_active;
    end
  end

endmodule

// File: rtl/reg_overlay_scan.sv
// Register-dump overlay front end: frame snapshot, stage-2 field lookup and blinking
// highlight, with the sync strobes carried through the same two flops as the pixel.
module reg_overlay_scan
  import overlay_pkg::*;
#(
  parameter int NUM_REGS     = 8,
  parameter int X0           = 64,
  parameter int Y0           = 32,
  parameter int SCALE_SHIFT  = 1,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [9:0]                px_x,
  input  logic [9:0]                px_y,
  input  logic                      px_active,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      frame_start,
  input  logic [REG_W*NUM_REGS-1:0] regs_in,
  input  logic                      hl_enable,
  input  logic [3:0]                hl_index,
  output logic [REG_W-1:0]          register,
  output logic [2:0]                line,
  output logic [4:0]                column,
  output logic                      glyph_valid,
  output logic                      highlight,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      active_out
);

  localparam int IDX_W = width_of(NUM_REGS);
  localparam int GY_W  = IDX_W + 3;
  localparam int CNT_W = width_of(BLINK_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [REG_W-1:0] snapshot [NUM_REGS];
  logic [CNT_W-1:0] frame_cnt;
  logic             blink_on;

  logic             s1_hit;
  logic [4:0]       s1_gx;
  logic [GY_W-1:0]  s1_gy;
  logic             s1_hsync;
  logic             s1_vsync;
  logic             s1_active;

  logic [IDX_W-1:0] idx;
  logic             hl_match;

  reg_overlay_hit #(
    .X0          (X0),
    .Y0          (Y0),
    .SCALE_SHIFT (SCALE_SHIFT),
    .ROWS        (NUM_REGS),
    .GY_W        (GY_W)
  ) u_hit (
    .clk       (clk),
    .reset     (reset),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_active (px_active),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .hit       (s1_hit),
    .gx        (s1_gx),
    .gy        (s1_gy),
    .hsync     (s1_hsync),
    .vsync     (s1_vsync),
    .active    (s1_active)
  );

  // Captured once per frame so a register changing mid-scan cannot tear its row.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) snapshot[k] <= '0;
    end else if (frame_start) begin
      for (int k = 0; k < NUM_REGS; k++) snapshot[k] <= regs_in[k*REG_W +: REG_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Indices at or above NUM_REGS cannot equal a real row, so they simply never match.
  assign idx      = s1_gy[GY_W-1:3];
  assign hl_match = (32'(idx) == 32'(hl_index));

  always_ff @(posedge clk) begin
    if (reset) begin
      register    <= '0;
      line        <= '0;
      column      <= '0;
      glyph_valid <= 1'b0;
      highlight   <= 1'b0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      active_out  <= 1'b0;
    end else begin
      register    <= s1_hit ? snapshot[idx] : '0;
      line        <= s1_hit ? s1_gy[2:0] : 3'd0;
      column      <= s1_hit ? s1_gx : 5'd0;
      glyph_valid <= s1_hit;
      highlight   <= s1_hit & hl_enable & hl_match & blink_on;
      hsync_out   <= s1_hsync;
      vsync_out   <= s1_vsync;
      active_out  <= s1_active;
    end
  end

endmodule

// File: tb/tb_reg_overlay_scan.sv
// Self-checking bench for reg_overlay_scan against an integer-arithmetic model of the
// window, snapshot and blink rules.
module tb_reg_overlay_scan;

  localparam int NR = 8;
  localparam int X0 = 64;
  localparam int Y0 = 32;
  localparam int S  = 1;
  localparam int BF = 30;

  logic            clk = 1'b0;
  logic            reset;
  logic [9:0]      px_x;
  logic [9:0]      px_y;
  logic            px_active;
  logic            hsync_in;
  logic            vsync_in;
  logic            frame_start;
  logic [16*NR-1:0] regs_in;
  logic            hl_enable;
  logic [3:0]      hl_index;
  logic [15:0]     register;
  logic [2:0]      line;
  logic [4:0]      column;
  logic            glyph_valid;
  logic            highlight;
  logic            hsync_out;
  logic            vsync_out;
  logic            active_out;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] snap_m [NR];
  int          frames_m;
  logic [28:0] obs;

  always #5 clk = ~clk;

  reg_overlay_scan #(
    .NUM_REGS     (NR),
    .X0           (X0),
    .Y0           (Y0),
    .SCALE_SHIFT  (S),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .px_x        (px_x),
    .px_y        (px_y),
    .px_active   (px_active),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .frame_start (frame_start),
    .regs_in     (regs_in),
    .hl_enable   (hl_enable),
    .hl_index    (hl_index),
    .register    (register),
    .line        (line),
    .column      (column),
    .glyph_valid (glyph_valid),
    .highlight   (highlight),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .active_out  (active_out)
  );

  assign obs = {glyph_valid, highlight, register, line, column, hsync_out, vsync_out, active_out};

  // Expected output vector for one pixel, given the bench's view of snapshot and blink.
  function automatic logic [28:0] model(int x, int y, bit act, bit hs, bit vs);
    int dx;
    int dy;
    int gx;
    int gy;
    int row;
    bit hit;
    bit hl;
    logic [15:0] r;
    logic [2:0]  ln;
    logic [4:0]  col;
    dx  = x - X0;
    dy  = y - Y0;
    hl  = 1'b0;
    r   = '0;
    ln  = '0;
    col = '0;
    hit = act && (dx >= 0) && (dy >= 0) && ((dx >> S) < 32) && ((dy >> S) < NR * 8);
    if (hit) begin
      gx  = dx >> S;
      gy  = dy >> S;
      row = gy / 8;
      r   = snap_m[row];
      ln  = 3'(gy % 8);
      col = 5'(gx);
      hl  = hl_enable && (int'(hl_index) == row) && (((frames_m / BF) % 2) == 0);
    end
    return {hit, hl, r, ln, col, hs, vs, act};
  endfunction

  task automatic drive(int x, int y, bit act, bit hs, bit vs);
    px_x      = 10'(x);
    px_y      = 10'(y);
    px_active = act;
    hsync_in  = hs;
    vsync_in  = vs;
  endtask

  task automatic hold_pixel(int x, int y, bit act, bit hs, bit vs);
    @(negedge clk);
    drive(x, y, act, hs, vs);
    repeat (2) @(negedge clk);
  endtask

  task automatic model_reset();
    frames_m = 0;
    for (int k = 0; k < NR; k++) snap_m[k] = '0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    frames_m++;
    for (int k = 0; k < NR; k++) snap_m[k] = regs_in[k*16 +: 16];
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic load_pattern();
    for (int k = 0; k < NR; k++) regs_in[k*16 +: 16] = 16'(32'h1111 * k);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    drive(64, 48, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    compared++;
    if (obs !== 29'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 29'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    int pts [5][2];
    logic [28:0] e;
    bit hs;
    bit vs;
    pts = '{'{64, 32}, '{64, 48}, '{70, 82}, '{100, 40}, '{90, 150}};
    load_pattern();
    pulse_frame();
    for (int i = 0; i < 5; i++) begin
      hs = 1'($urandom);
      vs = 1'($urandom);
      hold_pixel(pts[i][0], pts[i][1], 1'b1, hs, vs);
      e = model(pts[i][0], pts[i][1], 1'b1, hs, vs);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("[TB] FAIL basic_pixel(%0d,%0d): got %h expected %h", pts[i][0], pts[i][1], obs, e);
      end
      if (i == 0) begin
        compared++;
        if ({glyph_valid, register, line, column} !== {1'b1, 16'h0000, 3'd0, 5'd0}) begin
          mismatched++;
          $display("[TB] FAIL origin_fields: got v=%b r=%h l=%0d c=%0d expected v=1 r=0000 l=0 c=0",
                   glyph_valid, register, line, column);
        end
      end else if (i == 1) begin
        compared++;
        if ({register, line} !== {16'h1111, 3'd0}) begin
          mismatched++;
          $display("[TB] FAIL row1_fields: got r=%h l=%0d expected r=1111 l=0", register, line);
        end
      end else if (i == 2) begin
        compared++;
        if ({glyph_valid, register, line, column} !== {1'b1, 16'h3333, 3'd1, 5'd3}) begin
          mismatched++;
          $display("[TB] FAIL gy25_fields: got v=%b r=%h l=%0d c=%0d expected v=1 r=3333 l=1 c=3",
                   glyph_valid, register, line, column);
        end
      end
    end
  endtask

  task automatic test_boundaries();
    int pts [8][3];
    logic [28:0] e;
    pts = '{'{127, 32, 1}, '{128, 32, 0}, '{63, 32, 0}, '{64, 31, 0},
            '{64, 159, 1}, '{64, 160, 0}, '{1023, 1023, 0}, '{0, 0, 0}};
    for (int i = 0; i < 8; i++) begin
      hold_pixel(pts[i][0], pts[i][1], 1'b1, 1'b1, 1'b0);
      e = model(pts[i][0], pts[i][1], 1'b1, 1'b1, 1'b0);
      compared++;
      if (obs !== e || glyph_valid !== 1'(pts[i][2])) begin
        mismatched++;
        $display("[TB] FAIL edge_pixel(%0d,%0d): got %h expected %h (valid %0d)",
                 pts[i][0], pts[i][1], obs, e, pts[i][2]);
      end
    end
    hold_pixel(127, 32, 1'b1, 1'b0, 1'b0);
    compared++;
    if (column !== 5'd31) begin
      mismatched++;
      $display("[TB] FAIL right_column: got %0d expected 31", column);
    end
    hold_pixel(80, 40, 1'b0, 1'b0, 1'b1);
    e = model(80, 40, 1'b0, 1'b0, 1'b1);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("[TB] FAIL inactive_pixel: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_snapshot();
    logic [15:0] fresh;
    fresh = 16'($urandom) | 16'h8000;
    regs_in[16 +: 16] = fresh;
    hold_pixel(64, 48, 1'b1, 1'b0, 1'b0);
    compared++;
    if (register !== 16'h1111) begin
      mismatched++;
      $display("[TB] FAIL snapshot_hold: got %h expected %h", register, 16'h1111);
    end
    pulse_frame();
    hold_pixel(64, 48, 1'b1, 1'b0, 1'b0);
    compared++;
    if (register !== fresh) begin
      mismatched++;
      $display("[TB] FAIL snapshot_load: got %h expected %h", register, fresh);
    end
  endtask

  task automatic test_coincident();
    logic [15:0] old_v;
    logic [15:0] new_v;
    old_v = snap_m[1];
    new_v = ~old_v;
    @(negedge clk);
    drive(64, 48, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    regs_in[16 +: 16] = new_v;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    frames_m++;
    for (int k = 0; k < NR; k++) snap_m[k] = regs_in[k*16 +: 16];
    compared++;
    if (register !== old_v) begin
      mismatched++;
      $display("[TB] FAIL coincident_old: got %h expected %h", register, old_v);
    end
    @(negedge clk);
    compared++;
    if (register !== new_v) begin
      mismatched++;
      $display("[TB] FAIL coincident_new: got %h expected %h", register, new_v);
    end
  endtask

  task automatic test_blink();
    bit want [4];
    int pulses [4];
    pulses = '{0, 29, 1, 30};
    want   = '{1'b1, 1'b1, 1'b0, 1'b1};
    reset_dut();
    hl_enable = 1'b1;
    hl_index  = 4'd2;
    for (int p = 0; p < 4; p++) begin
      for (int n = 0; n < pulses[p]; n++) pulse_frame();
      hold_pixel(64, 64, 1'b1, 1'b0, 1'b0);
      compared++;
      if (highlight !== want[p] || obs !== model(64, 64, 1'b1, 1'b0, 1'b0)) begin
        mismatched++;
        $display("[TB] FAIL blink_row2_after_%0d: got %b expected %b", frames_m, highlight, want[p]);
      end
      hold_pixel(64, 80, 1'b1, 1'b0, 1'b0);
      compared++;
      if (highlight !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL blink_row3_after_%0d: got %b expected 0", frames_m, highlight);
      end
    end
    hl_index = 4'd9;
    for (int y = 32; y < 160; y += 16) begin
      hold_pixel(70, y, 1'b1, 1'b0, 1'b0);
      compared++;
      if (highlight !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL hl_index9_y%0d: got %b expected 0", y, highlight);
      end
    end
    hl_enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [28:0] e;
    load_pattern();
    pulse_frame();
    hold_pixel(64, 48, 1'b1, 1'b1, 1'b1);
    e = model(64, 48, 1'b1, 1'b1, 1'b1);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("[TB] FAIL pre_reset: got %h expected %h", obs, e);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (obs !== 29'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_zero: got %h expected %h", obs, 29'd0);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    compared++;
    if (obs !== 29'd0) begin
      mismatched++;
      $display("[TB] FAIL pipe_cleared: got %h expected %h", obs, 29'd0);
    end
    @(negedge clk);
    e = model(64, 48, 1'b1, 1'b1, 1'b1);
    compared++;
    if (obs !== e || register !== 16'h0000 || hsync_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL post_reset: got %h expected %h", obs, e);
    end
    pulse_frame();
    hold_pixel(64, 48, 1'b1, 1'b0, 1'b0);
    compared++;
    if (register !== 16'h1111) begin
      mismatched++;
      $display("[TB] FAIL post_reset_reload: got %h expected %h", register, 16'h1111);
    end
  endtask

  task automatic test_random_stream();
    logic [28:0] q [$];
    logic [28:0] e;
    int x;
    int y;
    bit act;
    bit hs;
    bit vs;
    for (int k = 0; k < NR; k++) regs_in[k*16 +: 16] = 16'($urandom);
    pulse_frame();
    hl_enable = 1'b1;
    hl_index  = 4'($urandom_range(0, 9));
    for (int i = 0; i < 402; i++) begin
      @(negedge clk);
      if (q.size() == 2) begin
        e = q.pop_front();
        compared++;
        if (obs !== e) begin
          mismatched++;
          $display("[TB] FAIL stream_cycle%0d: got %h expected %h", i, obs, e);
        end
      end
      if (i < 400) begin
        x   = int'($urandom_range(0, 220));
        y   = int'($urandom_range(0, 180));
        act = ($urandom_range(0, 9) < 8);
        hs  = 1'($urandom);
        vs  = 1'($urandom);
        drive(x, y, act, hs, vs);
        q.push_back(model(x, y, act, hs, vs));
      end
    end
    hl_enable = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    regs_in     = '0;
    hl_enable   = 1'b0;
    hl_index    = 4'd0;
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    model_reset();
    $display("[TB] starting reg_overlay_scan bench");
    test_reset();
    test_basic();
    test_boundaries();
    test_snapshot();
    test_coincident();
    test_blink();
    test_reset_mid();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
